// File: rtl/bfly_prio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bfly_prio_ctrl
// Brief    : Deterministic priority generator for the butterfly router levels:
//            rotating counter (advances on completed handshakes) or per-level
//            16-bit LFSRs (advance every enabled cycle).
// Revision : 1.0 - initial release
// ============================================================================
module bfly_prio_ctrl #(
    parameter int          NumOut     = 32,
    parameter int          NumLevels  = 5,
    parameter int          NumRouters = 16,
    parameter int          Randomize  = 0,
    parameter logic [15:0] LfsrSeed   = 16'hACE1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 en_i,
    input  logic [NumOut-1:0]                    req_i,
    input  logic [NumOut-1:0]                    gnt_i,
    input  logic                                 seed_load_i,
    input  logic [15:0]                          seed_i,
    output logic [NumLevels-1:0][NumRouters-1:0] prio_o,
    output logic                                 fire_o
);

    logic w_fire;
    logic r_fire;

    assign w_fire = en_i & (|(req_i & gnt_i));
    assign fire_o = r_fire;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fire <= 1'b0;
        end else begin
            r_fire <= w_fire;
        end
    end

    if (Randomize == 0) begin : g_cnt
        logic [NumLevels-1:0] r_cnt;
        logic                 w_unused_seed;

        assign w_unused_seed = ^seed_i;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt <= '0;
            end else if (seed_load_i) begin
                r_cnt <= '0;
            end else if (w_fire) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        // Counter MSB drives level 0, so the last level toggles on every fire.
        for (genvar l = 0; l < NumLevels; l++) begin : g_level
            assign prio_o[l] = {NumRouters{r_cnt[NumLevels-1-l]}};
        end
    end else begin : g_lfsr
        for (genvar l = 0; l < NumLevels; l++) begin : g_level
            localparam logic [15:0] c_seed_raw = LfsrSeed ^ 16'(l);
            localparam logic [15:0] c_seed_rst = (c_seed_raw == 16'h0000) ? 16'h0001 : c_seed_raw;

            logic [15:0] r_lfsr;
            logic [15:0] w_load_raw;
            logic [15:0] w_load;
            logic        w_fb;

            // An all-zero state would lock the LFSR, so zero loads become 1.
            assign w_load_raw = seed_i ^ 16'(l);
            assign w_load     = (w_load_raw == 16'h0000) ? 16'h0001 : w_load_raw;
            assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_lfsr <= c_seed_rst;
                end else if (seed_load_i) begin
                    r_lfsr <= w_load;
                end else if (en_i) begin
                    r_lfsr <= {r_lfsr[14:0], w_fb};
                end
            end

            for (genvar r = 0; r < NumRouters; r++) begin : g_router
                assign prio_o[l][r] = r_lfsr[r % 16];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bfly_prio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bfly_prio_ctrl
// Brief    : Directed bench for bfly_prio_ctrl in counter and LFSR modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bfly_prio_ctrl;

    localparam int NOUT = 32;
    localparam int NL   = 5;
    localparam int NR   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_ni;
    logic                   en_i;
    logic [NOUT-1:0]        req_i;
    logic [NOUT-1:0]        gnt_i;
    logic                   seed_load_i;
    logic [15:0]            seed_i;
    logic [NL-1:0][NR-1:0]  prio_c;
    logic [NL-1:0][NR-1:0]  prio_l;
    logic                   fire_c;
    logic                   fire_l;

    bfly_prio_ctrl #(
        .NumOut(NOUT), .NumLevels(NL), .NumRouters(NR), .Randomize(0), .LfsrSeed(16'hACE1)
    ) u_cnt (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .req_i(req_i), .gnt_i(gnt_i),
        .seed_load_i(seed_load_i), .seed_i(seed_i), .prio_o(prio_c), .fire_o(fire_c)
    );

    bfly_prio_ctrl #(
        .NumOut(NOUT), .NumLevels(NL), .NumRouters(NR), .Randomize(1), .LfsrSeed(16'hACE1)
    ) u_lfsr (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .req_i(req_i), .gnt_i(gnt_i),
        .seed_load_i(seed_load_i), .seed_i(seed_i), .prio_o(prio_l), .fire_o(fire_l)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [NL-1:0][NR-1:0] pc;
        logic [NL-1:0][NR-1:0] pl;
        logic                  fc;
        logic                  fl;
    } exp_t;

    exp_t              sb[$];
    logic [NL-1:0]     m_cnt;
    logic [15:0]       m_lfsr [NL];

    function automatic logic [15:0] guard(input logic [15:0] x);
        return (x == 16'h0000) ? 16'h0001 : x;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    function automatic logic [NL-1:0][NR-1:0] exp_prio_cnt(input logic [NL-1:0] c);
        logic [NL-1:0][NR-1:0] p;
        for (int l = 0; l < NL; l++)
            for (int r = 0; r < NR; r++)
                p[l][r] = c[NL-1-l];
        return p;
    endfunction

    function automatic logic [NL-1:0][NR-1:0] exp_prio_lfsr();
        logic [NL-1:0][NR-1:0] p;
        for (int l = 0; l < NL; l++)
            for (int r = 0; r < NR; r++)
                p[l][r] = m_lfsr[l][r % 16];
        return p;
    endfunction

    task automatic chk_w(input string tag, input logic [NL*NR-1:0] obs, input logic [NL*NR-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = '0;
        for (int l = 0; l < NL; l++) m_lfsr[l] = guard(16'hACE1 ^ 16'(l));
        sb.delete();
    endtask

    // Drives one cycle, pushes the model's post-edge expectation, compares after the edge.
    task automatic cycle(input logic en, input logic [NOUT-1:0] req, input logic [NOUT-1:0] gnt,
                         input logic load, input logic [15:0] seed);
        logic f;
        exp_t e;
        en_i = en; req_i = req; gnt_i = gnt; seed_load_i = load; seed_i = seed;
        f = en & (|(req & gnt));
        if (load)   m_cnt = '0;
        else if (f) m_cnt = m_cnt + 1'b1;
        for (int l = 0; l < NL; l++) begin
            if (load)    m_lfsr[l] = guard(seed ^ 16'(l));
            else if (en) m_lfsr[l] = lfsr_next(m_lfsr[l]);
        end
        sb.push_back('{pc: exp_prio_cnt(m_cnt), pl: exp_prio_lfsr(), fc: f, fl: f});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_w("prio_cnt", prio_c, e.pc);
        chk_w("prio_lfsr", prio_l, e.pl);
        chk_b("fire_cnt", fire_c, e.fc);
        chk_b("fire_lfsr", fire_l, e.fl);
    endtask

    initial begin
        rst_ni = 1'b0; en_i = 1'b0; req_i = '0; gnt_i = '0; seed_load_i = 1'b0; seed_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_w("rst_prio_cnt", prio_c, '0);
        chk_b("rst_fire_cnt", fire_c, 1'b0);
        chk_w("rst_lfsr0", {64'h0, prio_l[0]}, {64'h0, 16'hACE1});
        chk_w("rst_lfsr1", {64'h0, prio_l[1]}, {64'h0, 16'hACE0});
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk_w("post_rst_lfsr0", {64'h0, prio_l[0]}, {64'h0, 16'hACE1});

        // One enabled step, then enable low holds everything
        cycle(1'b1, '0, '0, 1'b0, '0);
        chk_w("lfsr_step1", {64'h0, prio_l[0]}, {64'h0, 16'h59C3});
        repeat (5) cycle(1'b0, '0, '0, 1'b0, '0);
        chk_w("lfsr_hold", {64'h0, prio_l[0]}, {64'h0, 16'h59C3});

        repeat (10) cycle(1'b1, '0, '0, 1'b0, '0);
        chk_w("idle_prio_cnt", prio_c, '0);

        repeat (3) cycle(1'b1, 32'h1, 32'h1, 1'b0, '0);
        chk_w("cnt3", prio_c, {16'hFFFF, 16'hFFFF, 48'h0});

        repeat (3) cycle(1'b1, 32'h1, 32'h0, 1'b0, '0);
        chk_w("req_no_gnt", prio_c, {16'hFFFF, 16'hFFFF, 48'h0});

        cycle(1'b1, 32'hF, 32'hF, 1'b0, '0);
        chk_w("multi_gnt", prio_c, {32'h0, 16'hFFFF, 32'h0});

        cycle(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0);
        chk_w("fire_no_en", prio_c, {32'h0, 16'hFFFF, 32'h0});

        cycle(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 16'h1234);
        chk_w("load_with_fire", prio_c, '0);

        repeat (31) cycle(1'b1, 32'h2, 32'h2, 1'b0, '0);
        chk_w("cnt31", prio_c, '1);
        cycle(1'b1, 32'h2, 32'h2, 1'b0, '0);
        chk_w("cnt_wrap", prio_c, '0);

        // Asynchronous reset asserted between edges during continuous fires
        repeat (3) cycle(1'b1, 32'h4, 32'h4, 1'b0, '0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_w("async_prio_cnt", prio_c, '0);
        chk_b("async_fire_cnt", fire_c, 1'b0);
        chk_b("async_fire_lfsr", fire_l, 1'b0);
        chk_w("async_lfsr0", {64'h0, prio_l[0]}, {64'h0, 16'hACE1});
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;

        // Zero seed load and full LFSR period
        cycle(1'b0, '0, '0, 1'b1, 16'h0000);
        chk_w("zero_load0", {64'h0, prio_l[0]}, {64'h0, 16'h0001});
        chk_w("zero_load1", {64'h0, prio_l[1]}, {64'h0, 16'h0001});
        for (int i = 0; i < 65535; i++) begin
            en_i = 1'b1; req_i = '0; gnt_i = '0; seed_load_i = 1'b0;
            for (int l = 0; l < NL; l++) m_lfsr[l] = lfsr_next(m_lfsr[l]);
            @(posedge clk);
            #1;
            checks++;
            assert (prio_l[0] !== 16'h0000) else begin
                errors++;
                $error("FAIL lfsr_nonzero step=%0d observed=%h expected=nonzero", i, prio_l[0]);
            end
        end
        chk_w("lfsr_period", prio_l, exp_prio_lfsr());
        chk_w("lfsr_period0", {64'h0, prio_l[0]}, {64'h0, 16'h0001});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
